// File: rtl/ram32x4_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram32x4_arbiter
// Brief    : Round-robin two-requester front end for the single-port ram32x4,
//            with read-latency tracking and per-requester read data return.
// Revision : 1.0
// ============================================================================
module ram32x4_arbiter #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_WIDTH-1:0] rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    logic                    r_prio;
    logic [READ_LATENCY-1:0] r_pipe_valid;
    logic [READ_LATENCY-1:0] r_pipe_id;
    logic [ADDR_WIDTH-1:0]   r_addr_hold;
    logic [DATA_WIDTH-1:0]   r_data_hold;
    logic [DATA_WIDTH-1:0]   r_rdata0;
    logic [DATA_WIDTH-1:0]   r_rdata1;

    logic                    w_gnt0;
    logic                    w_gnt1;
    logic                    w_any;
    logic                    w_sel;
    logic                    w_we;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic                    w_rvalid0;
    logic                    w_rvalid1;

    // A lone request always wins; on a tie r_prio names the winner.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!reset) begin
            if (req0 && (!req1 || !r_prio)) begin
                w_gnt0 = 1'b1;
            end else if (req1) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    assign w_any   = w_gnt0 | w_gnt1;
    assign w_sel   = w_gnt1;
    assign w_we    = w_sel ? we1    : we0;
    assign w_addr  = w_sel ? addr1  : addr0;
    assign w_wdata = w_sel ? wdata1 : wdata0;

    assign gnt0        = w_gnt0;
    assign gnt1        = w_gnt1;
    assign ram_wren    = w_any & w_we;
    assign ram_address = w_any ? w_addr  : r_addr_hold;
    assign ram_data    = w_any ? w_wdata : r_data_hold;

    // Returning reads are suppressed while reset is asserted so nothing in flight escapes.
    assign w_rvalid0 = !reset && r_pipe_valid[READ_LATENCY-1] && !r_pipe_id[READ_LATENCY-1];
    assign w_rvalid1 = !reset && r_pipe_valid[READ_LATENCY-1] &&  r_pipe_id[READ_LATENCY-1];

    assign rvalid0 = w_rvalid0;
    assign rvalid1 = w_rvalid1;
    assign rdata0  = w_rvalid0 ? ram_q : r_rdata0;
    assign rdata1  = w_rvalid1 ? ram_q : r_rdata1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio       <= 1'b0;
            r_pipe_valid <= '0;
            r_pipe_id    <= '0;
            r_addr_hold  <= '0;
            r_data_hold  <= '0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            if (w_any) begin
                r_prio      <= ~w_sel;
                r_addr_hold <= w_addr;
                r_data_hold <= w_wdata;
            end
            for (int i = READ_LATENCY - 1; i > 0; i--) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
                r_pipe_id[i]    <= r_pipe_id[i-1];
            end
            r_pipe_valid[0] <= w_any & ~w_we;
            r_pipe_id[0]    <= w_sel;
            if (w_rvalid0) begin
                r_rdata0 <= ram_q;
            end
            if (w_rvalid1) begin
                r_rdata1 <= ram_q;
            end
        end
    end

endmodule
`default_nettype wire
